// File: rtl/eth_tx_pad_fcs.sv
// Byte-wide AXI-Stream TX stage: pads a raw Ethernet frame with zeros up to
// MIN_FRAME_LEN bytes and appends the IEEE 802.3 CRC-32 FCS, LSB byte first.
module eth_tx_pad_fcs #(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int MIN_FRAME_LEN  = 60,
  parameter bit FCS_EN         = 1'b1
) (
  input  logic                      s_aclk,
  input  logic                      s_sresetn,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tuser,
  output logic                      s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  input  logic                      m_axis_trdy
);

  generate
    if (AXI_DATA_WIDTH != 8) begin : g_width_check
      $error("eth_tx_pad_fcs: only AXI_DATA_WIDTH = 8 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_FCS  = 2'd2
  } state_e;

  localparam logic [16:0] MIN_LEN_C = 17'(MIN_FRAME_LEN);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 32'hEDB8_8320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_e                      state_q, state_d;
  logic [31:0]                 crc_q, crc_d;
  logic [15:0]                 byte_cnt_q, byte_cnt_d;
  logic [1:0]                  fcs_idx_q, fcs_idx_d;
  logic                        err_q, err_d;
  logic                        run_q, run_d;
  logic [AXI_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic                        tuser_q, tuser_d;

  logic                        ld_s;
  logic                        trdy_s;
  logic                        accept_s;
  logic [16:0]                 cnt_next_s;
  logic [15:0]                 cnt_sat_s;
  logic [31:0]                 fcs_s;
  logic [7:0]                  fcs_byte_s;

  // run_q keeps the input closed for the first cycle after reset release
  assign ld_s       = !tvalid_q || m_axis_trdy;
  assign trdy_s     = run_q && (state_q == ST_DATA) && ld_s;
  assign accept_s   = s_axis_tvalid && trdy_s;
  assign cnt_next_s = {1'b0, byte_cnt_q} + 17'd1;
  assign cnt_sat_s  = (byte_cnt_q == 16'hFFFF) ? 16'hFFFF : (byte_cnt_q + 16'd1);
  assign fcs_s      = ~crc_q;

  // Select the FCS byte for the current index, least significant byte first.
  always_comb begin
    fcs_byte_s = 8'h00;
    case (fcs_idx_q)
      2'd0:    fcs_byte_s = fcs_s[7:0];
      2'd1:    fcs_byte_s = fcs_s[15:8];
      2'd2:    fcs_byte_s = fcs_s[23:16];
      2'd3:    fcs_byte_s = fcs_s[31:24];
      default: fcs_byte_s = 8'h00;
    endcase
  end

  // Next-state and output-register computation for the DATA/PAD/FCS sequencer.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    fcs_idx_d  = fcs_idx_q;
    err_d      = err_q;
    run_d      = 1'b1;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    case (state_q)
      ST_DATA: begin
        if (accept_s) begin
          tdata_d    = s_axis_tdata;
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          tuser_d    = 1'b0;
          crc_d      = crc32_byte(crc_q, s_axis_tdata);
          byte_cnt_d = cnt_sat_s;
          err_d      = err_q | s_axis_tuser;
          if (!s_axis_tlast) begin
            state_d = ST_DATA;
          end else if (cnt_next_s < MIN_LEN_C) begin
            state_d = ST_PAD;
          end else if (FCS_EN) begin
            state_d   = ST_FCS;
            fcs_idx_d = 2'd0;
          end else begin
            tlast_d    = 1'b1;
            tuser_d    = err_q | s_axis_tuser;
            crc_d      = CRC_INIT;
            byte_cnt_d = 16'd0;
            err_d      = 1'b0;
          end
        end else if (ld_s) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tuser_d  = 1'b0;
        end else begin
          tvalid_d = tvalid_q;
        end
      end
      ST_PAD: begin
        if (ld_s) begin
          tdata_d    = {AXI_DATA_WIDTH{1'b0}};
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
          tuser_d    = 1'b0;
          crc_d      = crc32_byte(crc_q, 8'h00);
          byte_cnt_d = cnt_sat_s;
          if (cnt_next_s < MIN_LEN_C) begin
            state_d = ST_PAD;
          end else if (FCS_EN) begin
            state_d   = ST_FCS;
            fcs_idx_d = 2'd0;
          end else begin
            state_d    = ST_DATA;
            tlast_d    = 1'b1;
            tuser_d    = err_q;
            crc_d      = CRC_INIT;
            byte_cnt_d = 16'd0;
            err_d      = 1'b0;
          end
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_FCS: begin
        if (ld_s) begin
          tdata_d   = fcs_byte_s;
          tvalid_d  = 1'b1;
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            state_d    = ST_DATA;
            tlast_d    = 1'b1;
            tuser_d    = err_q;
            crc_d      = CRC_INIT;
            byte_cnt_d = 16'd0;
            err_d      = 1'b0;
          end else begin
            tlast_d = 1'b0;
            tuser_d = 1'b0;
          end
        end else begin
          state_d = ST_FCS;
        end
      end
      default: begin
        state_d    = ST_DATA;
        crc_d      = CRC_INIT;
        byte_cnt_d = 16'd0;
        fcs_idx_d  = 2'd0;
        err_d      = 1'b0;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
      end
    endcase
  end

  // State, CRC accumulator and output register bank.
  always_ff @(posedge s_aclk or negedge s_sresetn) begin
    if (!s_sresetn) begin
      state_q    <= ST_DATA;
      crc_q      <= CRC_INIT;
      byte_cnt_q <= 16'd0;
      fcs_idx_q  <= 2'd0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
      tdata_q    <= {AXI_DATA_WIDTH{1'b0}};
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      byte_cnt_q <= byte_cnt_d;
      fcs_idx_q  <= fcs_idx_d;
      err_q      <= err_d;
      run_q      <= run_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
    end
  end

  assign s_axis_trdy   = trdy_s;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_eth_tx_pad_fcs.sv
// Scoreboard bench for eth_tx_pad_fcs: a default instance (pad to 60 + FCS)
// and a MIN_FRAME_LEN=0 instance for the "123456789" check-value frame.
module tb_eth_tx_pad_fcs;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst_n;
  logic       m_trdy;
  logic       stall_en;
  logic       chk_en;

  logic [7:0] a_tdata, b_tdata;
  logic       a_tvalid, b_tvalid, a_tlast, b_tlast, a_tuser, b_tuser;
  logic       a_trdy, b_trdy;
  logic [7:0] a_mdata, b_mdata;
  logic       a_mvalid, b_mvalid, a_mlast, b_mlast, a_muser, b_muser;

  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  int         n_cmp;
  int         n_err;
  logic       prev_stall[2];
  logic [10:0] prev_word[2];

  eth_tx_pad_fcs dut (
    .s_aclk(clk), .s_sresetn(rst_n),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast),
    .s_axis_tuser(a_tuser), .s_axis_trdy(a_trdy),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tlast(a_mlast),
    .m_axis_tuser(a_muser), .m_axis_trdy(m_trdy)
  );

  eth_tx_pad_fcs #(.MIN_FRAME_LEN(0)) dut0 (
    .s_aclk(clk), .s_sresetn(rst_n),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast),
    .s_axis_tuser(b_tuser), .s_axis_trdy(b_trdy),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tlast(b_mlast),
    .m_axis_tuser(b_muser), .m_axis_trdy(m_trdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready changes just after each rising edge.
  initial begin
    m_trdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_trdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Bit-serial reflected CRC-32 reference, returns the finished (inverted) FCS.
  function automatic logic [31:0] ref_fcs(input bq_t f);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (f[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ f[i][b];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  function automatic void push_frame(input bq_t d, input logic err);
    bq_t         f;
    logic [31:0] fcs;
    f = d;
    while (f.size() < 60) f.push_back(8'h00);
    fcs = ref_fcs(f);
    f.push_back(fcs[7:0]);
    f.push_back(fcs[15:8]);
    f.push_back(fcs[23:16]);
    f.push_back(fcs[31:24]);
    foreach (f[i]) begin
      if (i == f.size() - 1) exp_a.push_back({err, 1'b1, f[i]});
      else                   exp_a.push_back({1'b0, 1'b0, f[i]});
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_one(input int t, input logic v, input logic [7:0] d,
                         input logic l, input logic u);
    logic [9:0] e;
    logic       empty;
    if (prev_stall[t]) check($sformatf("stall_hold_%0d", t), {21'd0, v, u, l, d}, {21'd0, prev_word[t]});
    prev_stall[t] = v && !m_trdy;
    prev_word[t]  = {v, u, l, d};
    if (v && m_trdy) begin
      empty = (t == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
      if (empty) begin
        check($sformatf("unexpected_out_%0d", t), {22'd0, u, l, d}, 32'hFFFF_FFFF);
      end else begin
        e = (t == 0) ? exp_a.pop_front() : exp_b.pop_front();
        check($sformatf("out_byte_%0d", t), {22'd0, u, l, d}, {22'd0, e});
      end
    end
  endtask

  // Monitor: compares every transferred output byte against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      mon_one(0, a_mvalid, a_mdata, a_mlast, a_muser);
      mon_one(1, b_mvalid, b_mdata, b_mlast, b_muser);
    end else begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end
  end

  task automatic drive(input int t, input logic [7:0] d, input logic l, input logic u);
    if (t == 0) begin
      a_tdata = d; a_tvalid = 1'b1; a_tlast = l; a_tuser = u;
    end else begin
      b_tdata = d; b_tvalid = 1'b1; b_tlast = l; b_tuser = u;
    end
  endtask

  // Sends a frame; input valid stays high afterwards so frames can be chained.
  task automatic send(input int t, input bq_t d, input int user_idx, input bit last_en,
                      output int waits);
    int guard;
    waits = 0;
    foreach (d[i]) begin
      @(negedge clk);
      drive(t, d[i], last_en && (i == d.size() - 1), (i == user_idx));
      #1;
      guard = 0;
      while (((t == 0) ? a_trdy : b_trdy) !== 1'b1) begin
        waits++;
        guard++;
        if (guard > 500) begin
          check("send_timeout", 32'(guard), 32'd0);
          return;
        end
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
    b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    check(name, 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tdata"},  {24'd0, a_mdata}, 32'h0);
    check({tag, "_tvalid"}, {31'd0, a_mvalid}, 32'h0);
    check({tag, "_tlast"},  {31'd0, a_mlast}, 32'h0);
    check({tag, "_tuser"},  {31'd0, a_muser}, 32'h0);
    check({tag, "_trdy"},   {31'd0, a_trdy}, 32'h0);
  endtask

  initial begin
    bq_t        f1, f60, f10a, f10b, f100, s1;
    logic [7:0] s1_exp [13];
    int         w1, w2, wx;
    n_cmp = 0; n_err = 0;
    stall_en = 1'b0; chk_en = 1'b0; rst_n = 1'b0;
    prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
    a_tdata = 8'h00; a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
    b_tdata = 8'h00; b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;

    f1 = {8'hAA};
    for (int i = 0; i < 60; i++) f60.push_back(8'(i));
    for (int i = 0; i < 10; i++) f10a.push_back(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) f10b.push_back(8'(8'h20 + i));
    for (int i = 0; i < 100; i++) f100.push_back(8'(8'h80 + i));
    s1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    s1_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Check value frame through the no-padding instance.
    foreach (s1_exp[i]) exp_b.push_back({1'b0, (i == 12), s1_exp[i]});
    send(1, s1, -1, 1'b1, wx);
    idle();
    drain("drain_check_value");

    // Single-byte frame padded to 60 then FCS.
    push_frame(f1, 1'b0);
    send(0, f1, -1, 1'b1, wx);
    idle();
    drain("drain_one_byte");

    // 60-byte frame chained to a 1-byte frame: input blocked only during FCS.
    push_frame(f60, 1'b0);
    push_frame(f1, 1'b0);
    send(0, f60, -1, 1'b1, w1);
    send(0, f1, -1, 1'b1, w2);
    idle();
    check("fcs_trdy_low_cycles", 32'(w1 + w2), 32'd4);
    drain("drain_sixty");

    // Same 60-byte frame under random downstream back-pressure.
    stall_en = 1'b1;
    push_frame(f60, 1'b0);
    send(0, f60, -1, 1'b1, wx);
    idle();
    drain("drain_stalled");
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back short frames; the error flag must not leak into frame 2.
    push_frame(f10a, 1'b1);
    push_frame(f10b, 1'b0);
    send(0, f10a, 2, 1'b1, wx);
    send(0, f10b, -1, 1'b1, wx);
    idle();
    drain("drain_back_to_back");

    // Reset in the middle of a long frame, then a clean 1-byte frame.
    chk_en = 1'b0;
    f100 = f100[0:19];
    send(0, f100, -1, 1'b0, wx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    push_frame(f1, 1'b0);
    send(0, f1, -1, 1'b1, wx);
    idle();
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
